// File: rtl/saturating_counter_pkg.sv
// Shared constants and command encoding for the saturating counter.
// Optional sticky flag is controlled by SATURATING_COUNTER_STICKY_EN.
package saturating_counter_pkg;

   localparam int DEFAULT_WIDTH  = 16;
   localparam int DEFAULT_STEP_W = 8;

   typedef enum logic [1:0] {
      CMD_HOLD = 2'd0,
      CMD_LOAD = 2'd1,
      CMD_INC  = 2'd2,
      CMD_DEC  = 2'd3
   } cmd_e;

endpackage

// File: rtl/saturating_counter_sat_clamp.sv
// Combinational clamp of a signed WIDTH+1-bit candidate into [lo_limit, hi_limit].
// Shared by the load, increase and decrease paths of saturating_counter.
module sat_clamp #(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH:0]   cand_i,
   input  logic        [WIDTH-1:0] lo_limit,
   input  logic        [WIDTH-1:0] hi_limit,
   output logic        [WIDTH-1:0] value_o,
   output logic                    clamped_o
);

   logic signed [WIDTH:0] lo_s;
   logic signed [WIDTH:0] hi_s;

   assign lo_s = $signed({1'b0, lo_limit});
   assign hi_s = $signed({1'b0, hi_limit});

   always_comb begin
      value_o   = cand_i[WIDTH-1:0];
      clamped_o = 1'b0;
      if (cand_i > hi_s) begin
         value_o   = hi_limit;
         clamped_o = 1'b1;
      end else if (cand_i < lo_s) begin
         value_o   = lo_limit;
         clamped_o = 1'b1;
      end
   end

endmodule

// File: rtl/saturating_counter.sv
// Up/down counter that saturates into a programmable [lo_limit, hi_limit] window.
// Define SATURATING_COUNTER_STICKY_EN to add the sat_sticky output.
module saturating_counter
   import saturating_counter_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STEP_W = DEFAULT_STEP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              increase,
   input  logic              decrease,
   input  logic [STEP_W-1:0] step,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_value,
   input  logic [WIDTH-1:0]  lo_limit,
   input  logic [WIDTH-1:0]  hi_limit,
   input  logic              clear_sticky,
   output logic [WIDTH-1:0]  register,
   output logic              at_max,
   output logic              at_min,
   output logic              sat_pulse,
   output logic              limit_err
`ifdef SATURATING_COUNTER_STICKY_EN
   ,
   output logic              sat_sticky
`endif
);

   logic [WIDTH-1:0]      register_q, register_d;
   logic                  sat_pulse_q, sat_pulse_d;
   cmd_e                  cmd;
   logic [WIDTH:0]        step_ext;
   logic [WIDTH:0]        sum_u;
   logic                  inc_ovf;
   logic signed [WIDTH:0] cand;
   logic [WIDTH-1:0]      clamp_value;
   logic                  clamp_hit;

   assign limit_err = (lo_limit > hi_limit);
   assign at_max    = (register_q >= hi_limit);
   assign at_min    = (register_q <= lo_limit);

   always_comb begin
      cmd = CMD_HOLD;
      if (limit_err)              cmd = CMD_HOLD;
      else if (load)              cmd = CMD_LOAD;
      else if (increase && decrease) cmd = CMD_HOLD;
      else if (increase)          cmd = CMD_INC;
      else if (decrease)          cmd = CMD_DEC;
   end

   // An unsigned sum that carries into bit WIDTH cannot be represented as a
   // positive signed candidate, yet it is certainly above hi_limit: feed the
   // clamp the largest in-range value and force the clamped flag instead.
   always_comb begin
      step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
      sum_u    = {1'b0, register_q} + step_ext;
      inc_ovf  = sum_u[WIDTH];
      case (cmd)
         CMD_LOAD: cand = $signed({1'b0, load_value});
         CMD_INC:  cand = inc_ovf ? $signed({1'b0, {WIDTH{1'b1}}}) : $signed(sum_u);
         CMD_DEC:  cand = $signed({1'b0, register_q}) - $signed(step_ext);
         default:  cand = $signed({1'b0, register_q});
      endcase
   end

   sat_clamp #(.WIDTH(WIDTH)) u_clamp (
      .cand_i    (cand),
      .lo_limit  (lo_limit),
      .hi_limit  (hi_limit),
      .value_o   (clamp_value),
      .clamped_o (clamp_hit)
   );

   always_comb begin
      register_d  = register_q;
      sat_pulse_d = 1'b0;
      if (cmd != CMD_HOLD) begin
         register_d  = clamp_value;
         sat_pulse_d = clamp_hit | ((cmd == CMD_INC) & inc_ovf);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         register_q  <= '0;
         sat_pulse_q <= 1'b0;
      end else begin
         register_q  <= register_d;
         sat_pulse_q <= sat_pulse_d;
      end
   end

   assign register  = register_q;
   assign sat_pulse = sat_pulse_q;

`ifdef SATURATING_COUNTER_STICKY_EN
   logic sat_sticky_q, sat_sticky_d;

   always_comb begin
      sat_sticky_d = sat_sticky_q;
      if (sat_pulse_q)       sat_sticky_d = 1'b1;
      else if (clear_sticky) sat_sticky_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) sat_sticky_q <= 1'b0;
      else       sat_sticky_q <= sat_sticky_d;
   end

   assign sat_sticky = sat_sticky_q;
`else
   logic unused_clear_sticky;
   assign unused_clear_sticky = clear_sticky;
`endif

endmodule

// File: tb/tb_saturating_counter.sv
// Directed and randomized checks of saturating_counter against an arithmetic
// reference model (WIDTH=16, STEP_W=8).
module tb_saturating_counter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        increase = 1'b0;
   logic        decrease = 1'b0;
   logic [7:0]  step = '0;
   logic        load = 1'b0;
   logic [15:0] load_value = '0;
   logic [15:0] lo_limit = '0;
   logic [15:0] hi_limit = 16'hFFFF;
   logic        clear_sticky = 1'b0;
   logic [15:0] register_o;
   logic        at_max, at_min, sat_pulse, limit_err;
`ifdef SATURATING_COUNTER_STICKY_EN
   logic        sat_sticky;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   longint m_reg   = 0;
   bit     m_pulse = 0;
   bit     m_sticky = 0;

   saturating_counter #(.WIDTH(16), .STEP_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .increase     (increase),
      .decrease     (decrease),
      .step         (step),
      .load         (load),
      .load_value   (load_value),
      .lo_limit     (lo_limit),
      .hi_limit     (hi_limit),
      .clear_sticky (clear_sticky),
      .register     (register_o),
      .at_max       (at_max),
      .at_min       (at_min),
      .sat_pulse    (sat_pulse),
      .limit_err    (limit_err)
`ifdef SATURATING_COUNTER_STICKY_EN
      ,
      .sat_sticky   (sat_sticky)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model of one clock edge from the specification's rules.
   task automatic model_edge();
      longint lo, hi, cand, nr;
      bit     p;
      lo = longint'(lo_limit);
      hi = longint'(hi_limit);
      if (reset) begin
         m_sticky = 0;
      end else if (m_pulse) begin
         m_sticky = 1;
      end else if (clear_sticky) begin
         m_sticky = 0;
      end
      if (reset) begin
         nr = 0;
         p  = 0;
      end else if (lo > hi || (!load && (increase == decrease))) begin
         nr = m_reg;
         p  = 0;
      end else begin
         if (load)          cand = longint'(load_value);
         else if (increase) cand = m_reg + longint'(step);
         else               cand = m_reg - longint'(step);
         if (cand > hi)      nr = hi;
         else if (cand < lo) nr = lo;
         else                nr = cand;
         p = (nr != cand);
      end
      m_reg   = nr;
      m_pulse = p;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":register"}, 32'(register_o), 32'(m_reg));
      chk({tag, ":sat_pulse"}, 32'(sat_pulse), 32'(m_pulse));
      chk({tag, ":at_max"}, 32'(at_max), 32'(m_reg >= longint'(hi_limit)));
      chk({tag, ":at_min"}, 32'(at_min), 32'(m_reg <= longint'(lo_limit)));
      chk({tag, ":limit_err"}, 32'(limit_err), 32'(lo_limit > hi_limit));
`ifdef SATURATING_COUNTER_STICKY_EN
      chk({tag, ":sat_sticky"}, 32'(sat_sticky), 32'(m_sticky));
`endif
   endtask

   task automatic cyc(input string tag, input logic rst, input logic ld, input logic inc,
                      input logic dec, input logic [15:0] lv, input logic [7:0] st,
                      input logic [15:0] lo, input logic [15:0] hi, input logic clr);
      reset        = rst;
      load         = ld;
      increase     = inc;
      decrease     = dec;
      load_value   = lv;
      step         = st;
      lo_limit     = lo;
      hi_limit     = hi;
      clear_sticky = clr;
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [15:0] r_lo, r_hi, r_tmp;
      // reset
      cyc("reset", 1, 0, 0, 0, 16'h0, 8'd0, 16'h0, 16'hFFFF, 0);
      chk("reset_direct", 32'(register_o), 32'h0);
      // top-of-range increase saturates, pulse lasts one cycle
      cyc("ld_fffe", 0, 1, 0, 0, 16'hFFFE, 8'd0, 16'h0, 16'hFFFF, 0);
      cyc("inc_top", 0, 0, 1, 0, 16'h0, 8'd5, 16'h0, 16'hFFFF, 0);
      chk("inc_top_direct", {register_o, 15'b0, sat_pulse}, {16'hFFFF, 16'h1});
      cyc("inc_top_hold", 0, 0, 0, 0, 16'h0, 8'd5, 16'h0, 16'hFFFF, 0);
      chk("pulse_one_cycle", 32'(sat_pulse), 32'h0);
      // decrease into lo_limit
      cyc("ld_12", 0, 1, 0, 0, 16'd12, 8'd0, 16'd10, 16'd100, 0);
      cyc("dec_lo1", 0, 0, 0, 1, 16'h0, 8'd5, 16'd10, 16'd100, 0);
      cyc("dec_lo2", 0, 0, 0, 1, 16'h0, 8'd5, 16'd10, 16'd100, 0);
      chk("dec_lo2_direct", {register_o, 15'b0, sat_pulse}, {16'd10, 16'h1});
      // load clamping
      cyc("ld_500", 0, 1, 0, 0, 16'd500, 8'd0, 16'd10, 16'd100, 0);
      chk("ld_500_direct", 32'(register_o), 32'd100);
      cyc("ld_50", 0, 1, 0, 0, 16'd50, 8'd0, 16'd10, 16'd100, 0);
      // both directions hold, then inverted limits block everything
      cyc("inc_dec", 0, 0, 1, 1, 16'h0, 8'd3, 16'd10, 16'd100, 0);
      cyc("lerr_ld", 0, 1, 0, 0, 16'd15, 8'd3, 16'd20, 16'd10, 0);
      cyc("lerr_inc", 0, 0, 1, 0, 16'd15, 8'd3, 16'd20, 16'd10, 0);
      cyc("lerr_dec", 0, 0, 0, 1, 16'd15, 8'd3, 16'd20, 16'd10, 0);
      chk("lerr_direct", {register_o, 14'b0, limit_err, sat_pulse}, {16'd50, 16'h2});
      // reset wins over a same-cycle increase
      cyc("ld_40", 0, 1, 0, 0, 16'd40, 8'd0, 16'd0, 16'd100, 0);
      cyc("rst_inc", 1, 0, 1, 0, 16'd0, 8'd7, 16'd0, 16'd100, 0);
      // limits move under the register, step=0 clamps it
      cyc("ld_50b", 0, 1, 0, 0, 16'd50, 8'd0, 16'd0, 16'd100, 0);
      cyc("hi_30", 0, 0, 0, 0, 16'd0, 8'd0, 16'd0, 16'd30, 0);
      cyc("inc_s0", 0, 0, 1, 0, 16'd0, 8'd0, 16'd0, 16'd30, 0);
      chk("inc_s0_direct", {register_o, 15'b0, sat_pulse}, {16'd30, 16'h1});
      cyc("inc_s0_in", 0, 0, 1, 0, 16'd0, 8'd0, 16'd0, 16'd30, 0);
      // sticky set by the clamp above, then cleared
      cyc("clr_sticky", 0, 0, 0, 0, 16'd0, 8'd0, 16'd0, 16'd30, 1);
      cyc("after_clr", 0, 0, 0, 0, 16'd0, 8'd0, 16'd0, 16'd30, 0);
      // deep underflow below zero
      cyc("ld_3", 0, 1, 0, 0, 16'd3, 8'd0, 16'd0, 16'd100, 0);
      cyc("dec_uf", 0, 0, 0, 1, 16'd0, 8'd255, 16'd0, 16'd100, 0);
      // randomized traffic
      r_lo = 16'd100;
      r_hi = 16'd60000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            r_lo = 16'($urandom_range(0, 65535));
            r_hi = 16'($urandom_range(0, 65535));
            if (r_lo > r_hi && $urandom_range(0, 3) != 0) begin
               r_tmp = r_lo;
               r_lo  = r_hi;
               r_hi  = r_tmp;
            end
         end
         cyc("rand", ($urandom_range(0, 40) == 0), ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
             r_lo, r_hi, ($urandom_range(0, 7) == 0));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
